// File: rtl/proc_cu_pkg.sv
// Shared types and constants for the processor control unit: state and opcode
// encodings, register-file write-data selects and ALU operation codes.
package proc_cu_pkg;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_LDC    = 4'd9,
    S_JZ     = 4'd10,
    S_HALT   = 4'd11
  } state_t;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'd0,
    OP_STORE = 4'd1,
    OP_LOAD  = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_HALT  = 4'd5,
    OP_LDC   = 4'd6,
    OP_JZ    = 4'd7
  } opcode_t;

  localparam logic [1:0] RF_SEL_ALU   = 2'd0;
  localparam logic [1:0] RF_SEL_MEM   = 2'd1;
  localparam logic [1:0] RF_SEL_CONST = 2'd2;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

endpackage

// File: rtl/proc_pc_ir.sv
// Program counter and instruction register. A jump overrides the increment;
// the PC wraps naturally modulo 2^PCW.
module proc_pc_ir #(
  parameter int IW  = 16,
  parameter int PCW = 7
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           ir_load_i,
  input  logic           pc_inc_i,
  input  logic           pc_jump_i,
  input  logic [PCW-1:0] jump_target_i,
  input  logic [IW-1:0]  instr_i,
  output logic [PCW-1:0] pc_o,
  output logic [IW-1:0]  ir_o
);

  localparam logic [PCW-1:0] PC_ONE = {{(PCW-1){1'b0}}, 1'b1};

  logic [PCW-1:0] pc_q, pc_d;
  logic [IW-1:0]  ir_q, ir_d;

  always_comb begin
    pc_d = pc_q;
    ir_d = ir_q;
    if (ir_load_i) begin
      ir_d = instr_i;
    end else begin
      ir_d = ir_q;
    end
    if (pc_jump_i) begin
      pc_d = jump_target_i;
    end else if (pc_inc_i) begin
      pc_d = pc_q + PC_ONE;
    end else begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= {PCW{1'b0}};
      ir_q <= {IW{1'b0}};
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
    end
  end

  assign pc_o = pc_q;
  assign ir_o = ir_q;

endmodule

// File: rtl/proc_control_unit.sv
// Fetch/decode/execute control unit driving data memory, register file and ALU.
// Optional CU_ILLEGAL_TRAP_EN: opcodes 8-15 trap to HALT and set sticky Illegal.
module proc_control_unit
  import proc_cu_pkg::*;
#(
  parameter int IW  = 16,
  parameter int PCW = 7,
  parameter int DAW = 8,
  parameter int RAW = 4,
  parameter int CW  = 8
) (
  input  logic           Clk,
  input  logic           ResetN,
  input  logic [IW-1:0]  I_Data,
  input  logic           RF_Rp_Zero,
  input  logic           Resume,
  output logic [PCW-1:0] PC_Out,
  output logic [IW-1:0]  IR_Out,
  output logic [3:0]     State,
  output logic [3:0]     NextState,
  output logic [DAW-1:0] D_Addr,
  output logic           D_Wr,
  output logic [1:0]     RF_s,
  output logic [RAW-1:0] RF_W_Addr,
  output logic           RF_W_En,
  output logic [RAW-1:0] RF_Ra_Addr,
  output logic [RAW-1:0] RF_Rb_Addr,
  output logic [CW-1:0]  RF_Const,
  output logic [2:0]     ALU_s0,
  output logic           Halted
`ifdef CU_ILLEGAL_TRAP_EN
 ,output logic           Illegal
`endif
);

  state_t         state_q, state_d;
  logic           ir_load, pc_inc, pc_jump;
  logic [IW-1:0]  ir_q;
  logic [3:0]     opcode;

  assign opcode = ir_q[IW-1:IW-4];

`ifdef CU_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
`endif

  proc_pc_ir #(
    .IW  (IW),
    .PCW (PCW)
  ) u_pc_ir (
    .clk_i         (Clk),
    .rst_ni        (ResetN),
    .ir_load_i     (ir_load),
    .pc_inc_i      (pc_inc),
    .pc_jump_i     (pc_jump),
    .jump_target_i (PCW'(ir_q[7:0])),
    .instr_i       (I_Data),
    .pc_o          (PC_Out),
    .ir_o          (ir_q)
  );

  always_comb begin
    state_d    = state_q;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_jump    = 1'b0;
    D_Addr     = {DAW{1'b0}};
    D_Wr       = 1'b0;
    RF_s       = RF_SEL_ALU;
    RF_W_Addr  = {RAW{1'b0}};
    RF_W_En    = 1'b0;
    RF_Ra_Addr = {RAW{1'b0}};
    RF_Rb_Addr = {RAW{1'b0}};
    RF_Const   = {CW{1'b0}};
    ALU_s0     = ALU_PASS;
    Halted     = 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
    illegal_d  = illegal_q;
`endif
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH: begin
        ir_load = 1'b1;
        pc_inc  = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_NOOP:  state_d = S_NOOP;
          OP_STORE: state_d = S_STORE;
          OP_LOAD:  state_d = S_LOAD_A;
          OP_ADD:   state_d = S_ADD;
          OP_SUB:   state_d = S_SUB;
          OP_HALT:  state_d = S_HALT;
          OP_LDC:   state_d = S_LDC;
          OP_JZ:    state_d = S_JZ;
          default: begin
`ifdef CU_ILLEGAL_TRAP_EN
            state_d   = S_HALT;
            illegal_d = 1'b1;
`else
            state_d   = S_NOOP;
`endif
          end
        endcase
      end
      S_NOOP:   state_d = S_FETCH;
      S_LOAD_A, S_LOAD_B: begin
        D_Addr    = DAW'(ir_q[7:0]);
        RF_s      = RF_SEL_MEM;
        RF_W_Addr = RAW'(ir_q[11:8]);
        // Write only in the second cycle, once the memory read data is valid.
        if (state_q == S_LOAD_B) begin
          RF_W_En = 1'b1;
          state_d = S_FETCH;
        end else begin
          RF_W_En = 1'b0;
          state_d = S_LOAD_B;
        end
      end
      S_STORE: begin
        D_Addr     = DAW'(ir_q[7:0]);
        RF_Ra_Addr = RAW'(ir_q[11:8]);
        D_Wr       = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADD, S_SUB: begin
        RF_Ra_Addr = RAW'(ir_q[11:8]);
        RF_Rb_Addr = RAW'(ir_q[7:4]);
        RF_W_Addr  = RAW'(ir_q[3:0]);
        RF_s       = RF_SEL_ALU;
        RF_W_En    = 1'b1;
        if (state_q == S_ADD) begin
          ALU_s0 = ALU_ADD;
        end else begin
          ALU_s0 = ALU_SUB;
        end
        state_d = S_FETCH;
      end
      S_LDC: begin
        RF_Const  = CW'(ir_q[7:0]);
        RF_s      = RF_SEL_CONST;
        RF_W_Addr = RAW'(ir_q[11:8]);
        RF_W_En   = 1'b1;
        state_d   = S_FETCH;
      end
      S_JZ: begin
        RF_Ra_Addr = RAW'(ir_q[11:8]);
        pc_jump    = RF_Rp_Zero;
        state_d    = S_FETCH;
      end
      S_HALT: begin
        Halted = 1'b1;
        if (Resume) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_HALT;
        end
      end
      default:  state_d = S_INIT;
    endcase
  end

  // FSM state register; reset aborts any instruction in flight.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef CU_ILLEGAL_TRAP_EN
  // Sticky illegal-opcode flag, cleared only by reset.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign Illegal = illegal_q;
`endif

  assign State     = state_q;
  assign NextState = state_d;
  assign IR_Out    = ir_q;

endmodule
